modmul_issue_ctrl: RTL and testbench

MODMUL_ISSUE_CTRL -- requirements
Module: modmul_issue_ctrl

---
 rtl/modmul_issue_ctrl_pkg.sv | 14 +
 rtl/modmul_wdog_cnt.sv | 33 +++
 rtl/modmul_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_modmul_issue_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modmul_issue_ctrl_pkg.sv
// Shared definitions for the modular-multiplier issue controller: FSM state
// encoding and the default done-pulse timeout.
package modmul_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEFAULT_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/modmul_wdog_cnt.sv
// Wait-cycle watchdog: counts enabled cycles since the last clear and flags
// when the count reaches TIMEOUT_CYC-1.
module modmul_wdog_cnt #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_r;
    logic          expired_s;

    assign expired_s = (cnt_r == LIMIT);
    assign expired   = expired_s;

    // Counter register; parks at the limit so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (enable && !expired_s) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/modmul_issue_ctrl.sv
// Issue controller for a modular multiplier: accepts one job, pulses the
// multiplier start, waits for done or timeout, and holds the result until taken.
module modmul_issue_ctrl
    import modmul_issue_ctrl_pkg::*;
#(
    parameter int NBITS       = 128,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NBITS-1:0]   in_a,
    input  logic [NBITS-1:0]   in_b,
    input  logic               in_nmul,
    output logic [NBITS-1:0]   mm_a,
    output logic [NBITS-1:0]   mm_b,
    output logic               mm_nmul,
    output logic               mm_enable_p,
    input  logic               mm_done_irq_p,
    input  logic [NBITS-1:0]   mm_y,
    input  logic [2*NBITS-1:0] mm_y_nom_mul,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*NBITS-1:0] out_y,
    output logic               out_err,
    output logic               busy,
    output logic [15:0]        timeout_count
);

    state_t               state_r, state_s;
    logic                 accept_s, done_take_s, timeout_take_s;
    logic                 cnt_clear_s, cnt_en_s, cnt_expired_s;
    logic                 in_ready_r, busy_r, mm_enable_r, out_valid_r;
    logic [NBITS-1:0]     mm_a_r, mm_b_r;
    logic                 mm_nmul_r, out_err_r;
    logic [2*NBITS-1:0]   out_y_r;
    logic [15:0]          timeout_count_r;

    modmul_wdog_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear_s),
        .enable  (cnt_en_s),
        .expired (cnt_expired_s)
    );

    // Next-state logic; done outranks the timeout in the same cycle.
    always_comb begin
        state_s        = state_r;
        accept_s       = 1'b0;
        done_take_s    = 1'b0;
        timeout_take_s = 1'b0;
        cnt_clear_s    = 1'b0;
        cnt_en_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    state_s  = ISSUE;
                end else begin
                    state_s  = IDLE;
                end
            end
            ISSUE: begin
                cnt_clear_s = 1'b1;
                state_s     = WAIT;
            end
            WAIT: begin
                if (mm_done_irq_p) begin
                    done_take_s = 1'b1;
                    state_s     = HOLD;
                end else if (cnt_expired_s) begin
                    timeout_take_s = 1'b1;
                    state_s        = HOLD;
                end else begin
                    cnt_en_s = 1'b1;
                    state_s  = WAIT;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and handshake/status flags decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            mm_enable_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            busy_r      <= (state_s != IDLE);
            mm_enable_r <= (state_s == ISSUE);
            out_valid_r <= (state_s == HOLD);
        end
    end

    // Operand capture, result registration and timeout statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_a_r          <= {NBITS{1'b0}};
            mm_b_r          <= {NBITS{1'b0}};
            mm_nmul_r       <= 1'b0;
            out_y_r         <= {(2*NBITS){1'b0}};
            out_err_r       <= 1'b0;
            timeout_count_r <= 16'd0;
        end else begin
            if (accept_s) begin
                mm_a_r    <= in_a;
                mm_b_r    <= in_b;
                mm_nmul_r <= in_nmul;
            end
            if (done_take_s) begin
                out_y_r   <= mm_nmul_r ? mm_y_nom_mul : {{NBITS{1'b0}}, mm_y};
                out_err_r <= 1'b0;
            end else if (timeout_take_s) begin
                out_y_r   <= {(2*NBITS){1'b0}};
                out_err_r <= 1'b1;
                if (timeout_count_r != 16'hFFFF) begin
                    timeout_count_r <= timeout_count_r + 16'd1;
                end
            end
        end
    end

    assign in_ready      = in_ready_r;
    assign busy          = busy_r;
    assign mm_enable_p   = mm_enable_r;
    assign out_valid     = out_valid_r;
    assign mm_a          = mm_a_r;
    assign mm_b          = mm_b_r;
    assign mm_nmul       = mm_nmul_r;
    assign out_y         = out_y_r;
    assign out_err       = out_err_r;
    assign timeout_count = timeout_count_r;

endmodule

// File: tb/tb_modmul_issue_ctrl.sv
// Bench for modmul_issue_ctrl: two instances (long and short timeout) driven by
// a behavioural multiplier and a job-level timing/result model.
module tb_modmul_issue_ctrl;

    localparam int NB  = 128;
    localparam int TO0 = 1024;
    localparam int TO1 = 16;
    localparam logic [2*NB-1:0] MODP = 256'd11;

    logic              clk;
    logic              rst;
    logic              in_valid      [2];
    logic              in_ready      [2];
    logic [NB-1:0]     in_a          [2];
    logic [NB-1:0]     in_b          [2];
    logic              in_nmul       [2];
    logic [NB-1:0]     mm_a          [2];
    logic [NB-1:0]     mm_b          [2];
    logic              mm_nmul       [2];
    logic              mm_enable_p   [2];
    logic              mm_done_irq_p [2];
    logic [NB-1:0]     mm_y          [2];
    logic [2*NB-1:0]   mm_y_nom_mul  [2];
    logic              out_valid     [2];
    logic              out_ready     [2];
    logic [2*NB-1:0]   out_y         [2];
    logic              out_err       [2];
    logic              busy          [2];
    logic [15:0]       timeout_count [2];

    int checks = 0;
    int fails  = 0;
    int exp_tc [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        modmul_issue_ctrl #(.NBITS(NB), .TIMEOUT_CYC(g == 0 ? TO0 : TO1)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .in_valid      (in_valid[g]),
            .in_ready      (in_ready[g]),
            .in_a          (in_a[g]),
            .in_b          (in_b[g]),
            .in_nmul       (in_nmul[g]),
            .mm_a          (mm_a[g]),
            .mm_b          (mm_b[g]),
            .mm_nmul       (mm_nmul[g]),
            .mm_enable_p   (mm_enable_p[g]),
            .mm_done_irq_p (mm_done_irq_p[g]),
            .mm_y          (mm_y[g]),
            .mm_y_nom_mul  (mm_y_nom_mul[g]),
            .out_valid     (out_valid[g]),
            .out_ready     (out_ready[g]),
            .out_y         (out_y[g]),
            .out_err       (out_err[g]),
            .busy          (busy[g]),
            .timeout_count (timeout_count[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NB-1:0] rnd_nb();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (in_ready[u] !== 1'b1 || busy[u] !== 1'b0 || mm_enable_p[u] !== 1'b0 ||
                out_valid[u] !== 1'b0 || out_err[u] !== 1'b0) begin
                fails++;
                $display("FAIL reset_flags u%0d: rdy=%b busy=%b en=%b vld=%b err=%b want 1 0 0 0 0",
                         u, in_ready[u], busy[u], mm_enable_p[u], out_valid[u], out_err[u]);
            end
            checks++;
            if (out_y[u] !== '0 || mm_a[u] !== '0 || mm_b[u] !== '0 || mm_nmul[u] !== 1'b0 ||
                timeout_count[u] !== 16'd0) begin
                fails++;
                $display("FAIL reset_data u%0d: y=%h a=%h b=%h nmul=%b tc=%0d want all zero",
                         u, out_y[u], mm_a[u], mm_b[u], mm_nmul[u], timeout_count[u]);
            end
            exp_tc[u] = 0;
        end
        rst = 1'b0;
        tick();
    endtask

    // One job end to end. delay = cycles after the mm_enable_p cycle at which
    // the multiplier pulses done; bp = extra cycles out_ready is held low.
    task automatic run_job(input int u, input logic [NB-1:0] a, input logic [NB-1:0] b,
                           input logic nmul, input int delay, input int bp, input string name);
        int              to, rise, enables;
        logic [2*NB-1:0] prod, pmod, exp_y;
        logic [NB-1:0]   rmod;
        logic            exp_err;
        to   = (u == 0) ? TO0 : TO1;
        prod = {{NB{1'b0}}, a} * {{NB{1'b0}}, b};
        pmod = prod % MODP;
        rmod = pmod[NB-1:0];
        if (delay <= to) begin
            rise    = delay + 1;
            exp_err = 1'b0;
            exp_y   = nmul ? prod : {{NB{1'b0}}, rmod};
        end else begin
            rise    = to + 1;
            exp_err = 1'b1;
            exp_y   = '0;
            if (exp_tc[u] < 65535) exp_tc[u]++;
        end

        checks++;
        if (in_ready[u] !== 1'b1 || busy[u] !== 1'b0) begin
            fails++;
            $display("FAIL %s idle: in_ready=%b busy=%b want 1 0", name, in_ready[u], busy[u]);
        end
        in_a[u] = a; in_b[u] = b; in_nmul[u] = nmul; in_valid[u] = 1'b1;
        tick();
        in_valid[u] = 1'b0; in_a[u] = rnd_nb(); in_b[u] = rnd_nb(); in_nmul[u] = ~nmul;
        enables = int'(mm_enable_p[u]);
        checks++;
        if (mm_enable_p[u] !== 1'b1 || busy[u] !== 1'b1 || in_ready[u] !== 1'b0) begin
            fails++;
            $display("FAIL %s issue: en=%b busy=%b rdy=%b want 1 1 0",
                     name, mm_enable_p[u], busy[u], in_ready[u]);
        end

        for (int i = 1; i <= rise; i++) begin
            tick();
            mm_done_irq_p[u] = (i == delay);
            mm_y[u]          = (i == delay) ? rmod : rnd_nb();
            mm_y_nom_mul[u]  = (i == delay) ? prod : {rnd_nb(), rnd_nb()};
            enables += int'(mm_enable_p[u]);
            if (i < rise) begin
                checks++;
                if (out_valid[u] !== 1'b0) begin
                    fails++;
                    $display("FAIL %s early_valid: cycle %0d out_valid=%b want 0",
                             name, i, out_valid[u]);
                end
            end
        end

        checks++;
        if (out_valid[u] !== 1'b1 || out_err[u] !== exp_err || out_y[u] !== exp_y) begin
            fails++;
            $display("FAIL %s result: vld=%b err=%b y=%h want 1 %b %h",
                     name, out_valid[u], out_err[u], out_y[u], exp_err, exp_y);
        end
        checks++;
        if (enables !== 1 || timeout_count[u] !== 16'(exp_tc[u]) || mm_a[u] !== a ||
            mm_b[u] !== b || mm_nmul[u] !== nmul) begin
            fails++;
            $display("FAIL %s side: enables=%0d tc=%0d a_ok=%b b_ok=%b nmul=%b want 1 %0d 1 1 %b",
                     name, enables, timeout_count[u], mm_a[u] === a, mm_b[u] === b,
                     mm_nmul[u], exp_tc[u], nmul);
        end

        in_valid[u] = 1'b1;
        out_ready[u] = 1'b0;
        for (int j = 0; j < bp; j++) begin
            tick();
            mm_done_irq_p[u] = (j == 1);
            mm_y[u] = rnd_nb(); mm_y_nom_mul[u] = {rnd_nb(), rnd_nb()};
            checks++;
            if (out_valid[u] !== 1'b1 || out_y[u] !== exp_y || out_err[u] !== exp_err ||
                in_ready[u] !== 1'b0) begin
                fails++;
                $display("FAIL %s hold: cycle %0d vld=%b err=%b rdy=%b y=%h want 1 %b 0 %h",
                         name, j, out_valid[u], out_err[u], in_ready[u], out_y[u], exp_err, exp_y);
            end
        end
        out_ready[u] = 1'b1;
        tick();
        out_ready[u] = 1'b0; in_valid[u] = 1'b0; mm_done_irq_p[u] = 1'b0;
        checks++;
        if (out_valid[u] !== 1'b0 || in_ready[u] !== 1'b1 || busy[u] !== 1'b0 || mm_a[u] !== a) begin
            fails++;
            $display("FAIL %s release: vld=%b rdy=%b busy=%b a_kept=%b want 0 1 0 1",
                     name, out_valid[u], in_ready[u], busy[u], mm_a[u] === a);
        end
    endtask

    task automatic test_modular();
        run_job(0, 128'd5, 128'd7, 1'b0, 40, 0, "modular");
    endtask

    task automatic test_plain();
        logic [NB-1:0] ones;
        ones = '1;
        run_job(0, ones, 128'd2, 1'b1, 3, 0, "plain");
    endtask

    task automatic test_timeout();
        run_job(1, 128'd9, 128'd4, 1'b0, 1000, 0, "timeout");
    endtask

    task automatic test_backpressure();
        run_job(0, rnd_nb(), rnd_nb(), 1'b1, 5, 10, "backpressure");
    endtask

    task automatic test_stray_done();
        logic [2*NB-1:0] y_before;
        logic            err_before;
        y_before   = out_y[1];
        err_before = out_err[1];
        mm_done_irq_p[1] = 1'b1;
        mm_y[1] = rnd_nb(); mm_y_nom_mul[1] = {rnd_nb(), rnd_nb()};
        tick();
        mm_done_irq_p[1] = 1'b0;
        tick();
        checks++;
        if (in_ready[1] !== 1'b1 || busy[1] !== 1'b0 || out_valid[1] !== 1'b0 ||
            mm_enable_p[1] !== 1'b0 || out_y[1] !== y_before || out_err[1] !== err_before) begin
            fails++;
            $display("FAIL stray_idle: rdy=%b busy=%b vld=%b en=%b y_kept=%b err_kept=%b want 1 0 0 0 1 1",
                     in_ready[1], busy[1], out_valid[1], mm_enable_p[1],
                     out_y[1] === y_before, out_err[1] === err_before);
        end
        run_job(1, 128'd6, 128'd6, 1'b0, TO1, 0, "coincide");
        run_job(1, 128'd3, 128'd8, 1'b1, TO1 + 1, 2, "just_late");
    endtask

    task automatic test_reset_mid_wait();
        in_a[0] = rnd_nb(); in_b[0] = rnd_nb(); in_nmul[0] = 1'b1; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (busy[0] !== 1'b0 || in_ready[0] !== 1'b1 || mm_a[0] !== '0 || mm_nmul[0] !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: busy=%b rdy=%b a=%h nmul=%b want 0 1 0 0",
                     busy[0], in_ready[0], mm_a[0], mm_nmul[0]);
        end
        tick();
        rst = 1'b0;
        exp_tc[0] = 0;
        exp_tc[1] = 0;
        tick();
        mm_done_irq_p[0] = 1'b1;
        mm_y[0] = rnd_nb(); mm_y_nom_mul[0] = {rnd_nb(), rnd_nb()};
        tick();
        mm_done_irq_p[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
                out_y[0] !== '0 || out_err[0] !== 1'b0 || timeout_count[0] !== 16'd0 ||
                mm_enable_p[0] !== 1'b0) begin
                fails++;
                $display("FAIL late_done: vld=%b busy=%b rdy=%b y=%h err=%b tc=%0d en=%b want 0 0 1 0 0 0 0",
                         out_valid[0], busy[0], in_ready[0], out_y[0], out_err[0],
                         timeout_count[0], mm_enable_p[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            int u;
            u = (k % 3 == 2) ? 1 : 0;
            run_job(u, rnd_nb(), rnd_nb(), 1'($urandom_range(1, 0)),
                    (u == 0) ? int'($urandom_range(60, 1)) : int'($urandom_range(24, 1)),
                    int'($urandom_range(3, 0)), "random");
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0; in_a[u] = '0; in_b[u] = '0; in_nmul[u] = 1'b0;
            mm_done_irq_p[u] = 1'b0; mm_y[u] = '0; mm_y_nom_mul[u] = '0; out_ready[u] = 1'b0;
            exp_tc[u] = 0;
        end
        test_reset();
        test_modular();
        test_plain();
        test_timeout();
        test_backpressure();
        test_stray_done();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
